// File: rtl/rob_pkg.sv
// Shared ROB definitions: sizing defaults, tag width derivation and entry layout.
// Build option: ROB_FLUSH_EN adds flush recovery to rob_commit_unit and rob_wrap_ptr.
package rob_pkg;

  localparam int ROBSIZE_DEF = 16;
  localparam int ROB_DATA_W = 64;
  localparam logic [4:0] NO_DEST_REG = 5'd31;

  // Tag 0 is reserved for "value lives in the register file".
  function automatic int tag_width(input int size);
    return $clog2(size + 1);
  endfunction

  function automatic int ptr_width(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic [4:0]            dest;
    logic [ROB_DATA_W-1:0] value;
  } rob_entry_t;

endpackage

// File: rtl/rob_wrap_ptr.sv
// Modulo-SIZE pointer register used for ROB head and tail.
// Ports: clk, reset, inc, clear (ROB_FLUSH_EN only), ptr.
module rob_wrap_ptr
  import rob_pkg::*;
#(
  parameter int SIZE = ROBSIZE_DEF,
  parameter int W    = ptr_width(SIZE)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
`ifdef ROB_FLUSH_EN
  input  logic         clear,
`endif
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end
`ifdef ROB_FLUSH_EN
    else if (clear) begin
      ptr <= '0;
    end
`endif
    else if (inc) begin
      ptr <= (ptr == W'(SIZE - 1)) ? '0 : ptr + W'(1);
    end
  end

endmodule

// File: rtl/rob_commit_unit.sv
// Reorder buffer: allocates tags, captures writeback, retires in order, clears map.
// Ports: alloc_*, wb_*, src*_*, commit_*, map_*, count_o; flush_i with ROB_FLUSH_EN.
module rob_commit_unit
  import rob_pkg::*;
#(
  parameter int ROBSIZE = ROBSIZE_DEF,
  parameter int DATA_W  = ROB_DATA_W,
  parameter int TAG_W   = tag_width(ROBSIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_valid_i,
  input  logic [4:0]        alloc_dest_i,
  output logic              alloc_ready_o,
  output logic [TAG_W-1:0]  alloc_tag_o,
  input  logic              wb_valid_i,
  input  logic [TAG_W-1:0]  wb_tag_i,
  input  logic [DATA_W-1:0] wb_value_i,
  input  logic [TAG_W-1:0]  src1_tag_i,
  input  logic [TAG_W-1:0]  src2_tag_i,
  output logic              src1_ready_o,
  output logic              src2_ready_o,
  output logic [DATA_W-1:0] src1_value_o,
  output logic [DATA_W-1:0] src2_value_o,
  output logic              commit_valid_o,
  output logic [4:0]        commit_dest_o,
  output logic [TAG_W-1:0]  commit_tag_o,
  output logic [DATA_W-1:0] commit_value_o,
  input  logic [TAG_W-1:0]  map_commit_tag_i,
  output logic [31:0]       map_resets_o,
`ifdef ROB_FLUSH_EN
  input  logic              flush_i,
`endif
  output logic [TAG_W-1:0]  count_o
);

  localparam int PTR_W = ptr_width(ROBSIZE);

  rob_entry_t       entries [ROBSIZE];
  rob_entry_t       head_e;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] wb_idx;
  logic [TAG_W-1:0] count;
  logic             flush;
  logic             alloc_fire;
  logic             wb_hit;

`ifdef ROB_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  assign head_e        = entries[head];
  assign alloc_ready_o = count < TAG_W'(ROBSIZE);
  assign alloc_fire    = alloc_valid_i & alloc_ready_o & ~flush;
  assign alloc_tag_o   = TAG_W'(tail) + TAG_W'(1);
  assign count_o       = count;

  assign wb_idx = PTR_W'(wb_tag_i - TAG_W'(1));
  assign wb_hit = wb_valid_i && wb_tag_i != '0 &&
                  wb_tag_i <= TAG_W'(ROBSIZE) && entries[wb_idx].valid;

  assign commit_valid_o = head_e.valid & head_e.done & ~flush;
  assign commit_dest_o  = head_e.valid ? head_e.dest : '0;
  assign commit_tag_o   = head_e.valid ? TAG_W'(head) + TAG_W'(1) : '0;
  assign commit_value_o = head_e.valid ? DATA_W'(head_e.value) : '0;

  // Only clear when the map still points at us; a younger rename owns it otherwise.
  always_comb begin
    map_resets_o = '0;
    if (flush) begin
      map_resets_o = '1;
    end else if (commit_valid_o && commit_dest_o != NO_DEST_REG &&
                 map_commit_tag_i == commit_tag_o) begin
      map_resets_o[commit_dest_o] = 1'b1;
    end
  end

  logic [1:0][TAG_W-1:0]  src_tag;
  logic [1:0]             src_ready;
  logic [1:0][DATA_W-1:0] src_value;

  assign src_tag[0]   = src1_tag_i;
  assign src_tag[1]   = src2_tag_i;
  assign src1_ready_o = src_ready[0];
  assign src2_ready_o = src_ready[1];
  assign src1_value_o = src_value[0];
  assign src2_value_o = src_value[1];

  for (genvar s = 0; s < 2; s++) begin : g_src
    logic       in_range;
    logic       byp;
    rob_entry_t e;
    assign in_range = src_tag[s] != '0 && src_tag[s] <= TAG_W'(ROBSIZE);
    assign e        = entries[PTR_W'(src_tag[s] - TAG_W'(1))];
    assign byp      = wb_valid_i && wb_tag_i == src_tag[s];
    assign src_ready[s] = in_range & e.valid & (e.done | byp);
    assign src_value[s] = !in_range      ? '0 :
                          (byp & e.valid) ? wb_value_i :
                          DATA_W'(e.value);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ROBSIZE; i++) entries[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < ROBSIZE; i++) begin
        entries[i].valid <= 1'b0;
        entries[i].done  <= 1'b0;
      end
    end else begin
      if (wb_hit) begin
        entries[wb_idx].done  <= 1'b1;
        entries[wb_idx].value <= ROB_DATA_W'(wb_value_i);
      end
      if (alloc_fire) begin
        entries[tail] <= '{valid: 1'b1, done: 1'b0,
                           dest: alloc_dest_i, value: '0};
      end
      if (commit_valid_o) begin
        entries[head].valid <= 1'b0;
        entries[head].done  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count <= '0;
    end else if (alloc_fire && !commit_valid_o) begin
      count <= count + TAG_W'(1);
    end else if (!alloc_fire && commit_valid_o) begin
      count <= count - TAG_W'(1);
    end
  end

  rob_wrap_ptr #(.SIZE(ROBSIZE), .W(PTR_W)) u_head (
    .clk   (clk),
    .reset (reset),
    .inc   (commit_valid_o),
`ifdef ROB_FLUSH_EN
    .clear (flush),
`endif
    .ptr   (head)
  );

  rob_wrap_ptr #(.SIZE(ROBSIZE), .W(PTR_W)) u_tail (
    .clk   (clk),
    .reset (reset),
    .inc   (alloc_fire),
`ifdef ROB_FLUSH_EN
    .clear (flush),
`endif
    .ptr   (tail)
  );

endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
- Reorder buffer for the out-of-order core. It allocates ROB tags at decode, which the map table stores as rename values.
- It captures results from writeback and retires entries in program order.
- At commit it drives the map table's commit-side port: it presents the architectural register, reads back that register's current mapping, and asserts a one-hot clear when that mapping still names the committing tag.
- It is the producer of the tags and clears that the map table consumes.

Parameters:
- ROBSIZE, 16, number of entries.
- TAG_W, $clog2(ROBSIZE+1), tag width. Tag 0 means "not renamed / value in register file". Tags 1..ROBSIZE map to entry index tag-1.
- DATA_W, 64, result width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- alloc_valid_i  in  1  decode requests an entry.
- alloc_dest_i  in  5  destination architectural register; 31 = no destination (zero register).
- alloc_ready_o  out  1  entry available.
- alloc_tag_o  out  TAG_W  tag of current tail; written into the map table by decode.
- wb_valid_i  in  1  writeback result valid.
- wb_tag_i  in  TAG_W  tag being written back.
- wb_value_i  in  DATA_W  result.
- src1_tag_i, src2_tag_i  in  TAG_W  operand tags read from the map table.
- src1_ready_o, src2_ready_o  out  1  operand value available in the ROB.
- src1_value_o, src2_value_o  out  DATA_W  operand value.
- commit_valid_o  out  1  head entry retires this cycle.
- commit_dest_o  out  5  head destination; drives the map table commit read address.
- commit_tag_o  out  TAG_W  head tag.
- commit_value_o  out  DATA_W  value written to the architectural register file.
- map_commit_tag_i  in  TAG_W  map table's current mapping for commit_dest_o, combinational same cycle.
- map_resets_o  out  32  one-hot clear to the map table.
- count_o  out  TAG_W  occupancy.
- flush_i  in  1  present only with ROB_FLUSH_EN.

Behaviour:
- Reset: head=0, tail=0, count=0, all entry valid/done bits=0.
  - Output values after reset: alloc_ready_o=1, alloc_tag_o=1, commit_valid_o=0, map_resets_o=0, count_o=0, src*_ready_o=0.
- Circular buffer. Pointers wrap from ROBSIZE-1 to 0. alloc_tag_o = tail+1.
- Allocate: fires when alloc_valid_i & alloc_ready_o. At the edge the tail entry becomes valid=1, done=0, dest stored, and tail advances.
  - alloc_ready_o = (count < ROBSIZE), taken from registered count. A full ROB refuses allocation even in a cycle where it commits.
- Writeback: fires when wb_valid_i and entry[wb_tag_i-1] is valid. At the edge it sets done=1 and stores the value.
  - wb_tag_i=0 or a non-valid entry is ignored. A repeated writeback overwrites the value.
- Source read (combinational):
  - Tag 0 gives ready=0, value=0.
  - Otherwise ready = valid & (done | (wb_valid_i & wb_tag_i==tag)). The same-cycle writeback value is bypassed.
- Commit: commit_valid_o = entry[head].valid & entry[head].done, combinational. No retire handshake.
  - At the edge the head entry is invalidated and head advances.
  - Maximum of one commit per cycle.
  - commit_dest_o, commit_tag_o and commit_value_o reflect the head entry whenever it is valid. They are 0 when the buffer is empty.
- Map clear: map_resets_o[commit_dest_o] = commit_valid_o & commit_dest_o!=31 & map_commit_tag_i==commit_tag_o. All other bits are 0.
  - A stale mapping (a younger writer renamed the register) produces no clear.
- Count: +1 on alloc only, -1 on commit only, unchanged when both occur.
- Latency:
  - An allocated entry can commit no earlier than the cycle after its writeback edge.
  - A writeback to the head in cycle N gives commit_valid_o=1 in cycle N+1.
- Reset mid-operation discards all entries. The map table is cleared by its own reset.

Optional Feature:
- ROB_FLUSH_EN: adds flush_i for misprediction recovery.
  - When defined and flush_i=1: at the edge all entries are invalidated, head=tail=0 and count=0. In the same cycle map_resets_o=32'hFFFF_FFFF and commit_valid_o is forced 0.
  - Decode must not allocate in a flush cycle; an allocation in that cycle is dropped.
  - When undefined: no flush_i port and no flush logic.

Decomposition:
- Shared package rob_pkg:
  - ROBSIZE default and the TAG_W derivation.
  - NO_DEST_REG=5'd31.
  - rob_entry_t struct {valid, done, dest[4:0], value[DATA_W-1:0]}.
- One sub-module, rob_wrap_ptr: a modulo-ROBSIZE pointer register with reset, increment enable and (under the macro) clear. It is instantiated for head and tail.

Test Plan (ROBSIZE=8, DATA_W=64):
1. Reset, then allocate 8 entries with dest 1..8 -> alloc_tag_o 1..8 in sequence, alloc_ready_o=0 after the 8th, count_o=8; a 9th request is not accepted.
2. Writeback tag 3 value 0xDEAD, then later tags 1 and 2 -> no commit before tag 1 is done; then commits tags 1,2,3 on consecutive cycles, with commit_value_o=0xDEAD on the third.
3. Head tag 2, dest 5, map_commit_tag_i=2 -> map_resets_o=32'h0000_0020; repeated with map_commit_tag_i=6 -> map_resets_o=0 and commit still occurs.
4. Entry with dest 31 done at head -> commit_valid_o=1, map_resets_o=0.
5. Fill 8, commit 3, allocate 3 -> tags 1,2,3 are reused; src1_tag_i=1 gives ready=0; writeback tag 1 in the same cycle gives ready=1 with the bypassed value.
6. With ROB_FLUSH_EN, 5 entries in flight, flush_i=1 -> next cycle count_o=0 and alloc_tag_o=1; in the flush cycle map_resets_o=32'hFFFF_FFFF and commit_valid_o=0.
